// File: rtl/mul256_seq.sv
// mul256_seq: multi-cycle unsigned WIDTH x WIDTH multiplier (schoolbook over
// LIMB-bit limbs, one partial product per clock into a 2*WIDTH accumulator).
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  operation request, sampled only while idle
//   sq     square request (honoured only when MUL_SQUARE_EN is defined)
//   a, b   WIDTH-bit operands, latched when start is accepted
//   busy   operation in progress
//   done   one-cycle pulse, p valid
//   p      2*WIDTH-bit product, held until the next done or reset
//
// Build option: define MUL_SQUARE_EN to add the squaring path (only limb
// pairs i<=j are visited, off-diagonal terms doubled). Without it, sq is
// ignored and every operation is a full N*N multiply.
module mul256_seq #(
    parameter int WIDTH = 256,
    parameter int LIMB  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sq,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int N  = WIDTH / LIMB;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(2 * WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]   a_r, b_r;
    logic [IW-1:0]      i_r, j_r;
    logic [2*WIDTH-1:0] acc, term;
    logic [LIMB-1:0]    a_limb, b_limb;
    logic [2*LIMB-1:0]  prod;
    logic [SW-1:0]      shamt;
    logic               last_pair;

`ifdef MUL_SQUARE_EN
    logic sq_r;
`else
    logic sq_unused;
    assign sq_unused = sq;
`endif

    // Partial product for the current limb pair, aligned to its weight.
    always_comb begin
        a_limb = a_r[i_r*LIMB +: LIMB];
`ifdef MUL_SQUARE_EN
        b_limb = sq_r ? a_r[j_r*LIMB +: LIMB] : b_r[j_r*LIMB +: LIMB];
`else
        b_limb = b_r[j_r*LIMB +: LIMB];
`endif
        prod  = {{LIMB{1'b0}}, a_limb} * {{LIMB{1'b0}}, b_limb};
        shamt = SW'(LIMB) * (SW'(i_r) + SW'(j_r));
`ifdef MUL_SQUARE_EN
        // Off-diagonal pairs stand in for both (i,j) and (j,i): double them.
        if (sq_r && (i_r != j_r))
            shamt = shamt + 1'b1;
`endif
        term = '0;
        term[2*LIMB-1:0] = prod;
        term = term << shamt;
        last_pair = (i_r == IW'(N - 1)) && (j_r == IW'(N - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MUL;
            MUL:     if (last_pair) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == MUL) || (state == DONE);
    end

    // Datapath: operand latch, limb counters, accumulator, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            i_r  <= '0;
            j_r  <= '0;
            acc  <= '0;
            p    <= '0;
            done <= 1'b0;
`ifdef MUL_SQUARE_EN
            sq_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        i_r <= '0;
                        j_r <= '0;
`ifdef MUL_SQUARE_EN
                        sq_r <= sq;
`endif
                    end
                end
                MUL: begin
                    acc <= acc + term;
                    if (j_r == IW'(N - 1)) begin
                        i_r <= i_r + 1'b1;
`ifdef MUL_SQUARE_EN
                        // Squaring walks the upper triangle: j restarts at the new i.
                        j_r <= sq_r ? IW'(i_r + 1'b1) : '0;
`else
                        j_r <= '0;
`endif
                    end else begin
                        j_r <= j_r + 1'b1;
                    end
                end
                DONE: begin
                    p    <= acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul256_seq.sv
// tb_mul256_seq: directed and random self-checking bench for mul256_seq.
module tb_mul256_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sq;
    logic [255:0] a;
    logic [255:0] b;
    logic         busy;
    logic         done;
    logic [511:0] p;

    int checks = 0;
    int errors = 0;

    mul256_seq #(.WIDTH(256), .LIMB(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sq    (sq),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        r = '0;
        for (int unsigned k = 0; k < 8; k++)
            r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Called just after an edge; counts further edges until done (bounded).
    task automatic wait_done(output int n, output bit bok);
        n   = 0;
        bok = busy;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!done) bok &= busy;
        end
    endtask

    task automatic run_op(input string tag, input logic [255:0] av, input logic [255:0] bv,
                          input logic sqv, input logic [511:0] exp, input int lat);
        int n;
        bit bok;
        @(negedge clk);
        a = av; b = bv; sq = sqv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, bok);
        check({tag, "_lat"}, 512'(n), 512'(lat));
        check({tag, "_busy"}, 512'(bok), 512'd1);
        check({tag, "_busy_at_done"}, 512'(busy), 512'd0);
        check({tag, "_p"}, p, exp);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 512'(done), 512'd0);
    endtask

    initial begin
        int n;
        bit bok;
        int pulses;
        logic [255:0] ra, rb;
        logic [511:0] ones_sq;

        ones_sq = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
        rst = 1'b1; start = 1'b0; sq = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_done", 512'(done), 512'd0);
        check("rst_p", p, 512'd0);
        @(negedge clk); rst = 1'b0;

        // 1..3: basic products and limb alignment
        run_op("one", 256'd1, 256'd1, 1'b0, 512'd1, 17);
        run_op("ones", '1, '1, 1'b0, ones_sq, 17);
        run_op("shift", 256'd1 << 64, 256'd1 << 192, 1'b0, 512'd1 << 256, 17);

        // 4a: start re-pulsed mid-operation with new operands is ignored
        @(negedge clk);
        a = 256'd3; b = 256'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        a = 256'd7; b = 256'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, bok);
        check("reissue_lat", 512'(n + 5), 512'd17);
        check("reissue_p", p, 512'd15);
        @(posedge clk); #1;

        // 4b: start held through done, second op taken at the done-cycle edge
        @(negedge clk);
        a = 256'd3; b = 256'd5; start = 1'b1;
        @(posedge clk); #1;
        a = 256'd6; b = 256'd7;
        wait_done(n, bok);
        check("b2b_first_lat", 512'(n), 512'd17);
        check("b2b_first_p", p, 512'd15);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept_busy", 512'(busy), 512'd1);
        wait_done(n, bok);
        check("b2b_second_lat", 512'(n), 512'd17);
        check("b2b_second_p", p, 512'd42);
        check("b2b_second_busy", 512'(bok), 512'd1);
        @(posedge clk); #1;

        // 5: reset mid-MUL aborts with no done pulse and clears p
        @(negedge clk);
        a = 256'd9; b = 256'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 512'(busy), 512'd0);
        check("abort_done", 512'(done), 512'd0);
        check("abort_p", p, 512'd0);
        pulses = 0;
        repeat (20) begin @(posedge clk); #1; if (done) pulses++; end
        check("abort_no_done", 512'(pulses), 512'd0);
        run_op("after_abort", 256'd12345, 256'd67890, 1'b0, 512'd838102050, 17);

        // 6: squaring option
`ifdef MUL_SQUARE_EN
        run_op("sq_ones", '1, 256'd5, 1'b1, ones_sq, 11);
        run_op("sq_mixed", (256'd1 << 200) | 256'd3, 256'd0, 1'b1,
               (512'd1 << 400) | (512'd3 << 201) | 512'd9, 11);
`else
        run_op("sq_ignored", 256'd3, 256'd5, 1'b1, 512'd15, 17);
`endif

        // Random multiply suite against a wide reference product
        for (int unsigned t = 0; t < 1000; t++) begin
            ra = rnd256();
            rb = rnd256();
            @(negedge clk);
            a = ra; b = rb; sq = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(n, bok);
            check("rand_lat", 512'(n), 512'd17);
            check("rand_p", p, {256'd0, ra} * {256'd0, rb});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
